// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: wraps a byte stream in preamble/SFD, zero-pads short frames,
// appends the Ethernet FCS and enforces the inter-frame gap. Underrun aborts with one TxEr cycle.
module gmii_tx_framer #(
  parameter int IFG_CYCLES = 12,
  parameter int MIN_BYTES  = 60,
  parameter bit PAD_EN     = 1'b1
) (
  input  logic        txClk,
  input  logic        rst,
  input  logic [7:0]  dataIn,
  input  logic        validIn,
  input  logic        lastIn,
  output logic        readyOut,
  output logic [7:0]  gmiiTxd,
  output logic        gmiiTxEn,
  output logic        gmiiTxEr,
  output logic        busyOut,
  output logic [15:0] frameCntOut
);

  localparam logic [15:0] MIN_B    = 16'(MIN_BYTES);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_CYCLES - 1);
  localparam logic [7:0]  PRE_LAST = 8'd6;

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_ERR, S_DROP, S_IFG
  } state_t;

  // The state always names the phase of the byte currently on the wire.
  state_t        r_state, w_state;
  logic [7:0]    r_txd, w_txd;
  logic          r_txEn, w_txEn;
  logic          r_txEr, w_txEr;
  logic [7:0]    r_phase, w_phase;
  logic [31:0]   r_crc, w_crc;
  logic [15:0]   r_bytes, w_bytes;
  logic          r_last, w_last;
  logic [15:0]   r_frameCnt, w_frameCnt;
  logic [31:0]   w_fcs;
  logic          w_padNeeded;

  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign readyOut    = (r_state == S_SFD) || (r_state == S_DATA && !r_last) || (r_state == S_DROP);
  assign busyOut     = (r_state != S_IDLE);
  assign gmiiTxd     = r_txd;
  assign gmiiTxEn    = r_txEn;
  assign gmiiTxEr    = r_txEr;
  assign frameCntOut = r_frameCnt;
  assign w_fcs       = ~r_crc;
  assign w_padNeeded = PAD_EN && (r_bytes < MIN_B);

  always_ff @(posedge txClk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_txd      <= 8'h00;
      r_txEn     <= 1'b0;
      r_txEr     <= 1'b0;
      r_phase    <= 8'd0;
      r_crc      <= 32'hFFFFFFFF;
      r_bytes    <= 16'd0;
      r_last     <= 1'b0;
      r_frameCnt <= 16'd0;
    end else begin
      r_state    <= w_state;
      r_txd      <= w_txd;
      r_txEn     <= w_txEn;
      r_txEr     <= w_txEr;
      r_phase    <= w_phase;
      r_crc      <= w_crc;
      r_bytes    <= w_bytes;
      r_last     <= w_last;
      r_frameCnt <= w_frameCnt;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_txd      = 8'h00;
    w_txEn     = 1'b0;
    w_txEr     = 1'b0;
    w_phase    = r_phase;
    w_crc      = r_crc;
    w_bytes    = r_bytes;
    w_last     = r_last;
    w_frameCnt = r_frameCnt;
    case (r_state)
      S_IDLE: begin
        if (validIn) begin
          w_state = S_PRE;
          w_txd   = 8'h55;
          w_txEn  = 1'b1;
          w_phase = 8'd0;
          w_crc   = 32'hFFFFFFFF;
          w_bytes = 16'd0;
          w_last  = 1'b0;
        end
      end
      S_PRE: begin
        w_txEn = 1'b1;
        if (r_phase == PRE_LAST) begin
          w_state = S_SFD;
          w_txd   = 8'hD5;
        end else begin
          w_phase = r_phase + 8'd1;
          w_txd   = 8'h55;
        end
      end
      S_SFD, S_DATA: begin
        w_txEn = 1'b1;
        if (readyOut) begin
          if (validIn) begin
            w_state = S_DATA;
            w_txd   = dataIn;
            w_crc   = crc_step(r_crc, dataIn);
            w_bytes = sat_inc(r_bytes);
            w_last  = lastIn;
          end else begin
            // Nothing to send while the wire is committed: abort the frame.
            w_state = S_ERR;
            w_txEr  = 1'b1;
          end
        end else if (w_padNeeded) begin
          w_state = S_PAD;
          w_crc   = crc_step(r_crc, 8'h00);
          w_bytes = sat_inc(r_bytes);
        end else begin
          w_state = S_FCS;
          w_txd   = w_fcs[7:0];
          w_phase = 8'd0;
        end
      end
      S_PAD: begin
        w_txEn = 1'b1;
        if (w_padNeeded) begin
          w_crc   = crc_step(r_crc, 8'h00);
          w_bytes = sat_inc(r_bytes);
        end else begin
          w_state = S_FCS;
          w_txd   = w_fcs[7:0];
          w_phase = 8'd0;
        end
      end
      S_FCS: begin
        if (r_phase[1:0] == 2'd3) begin
          w_state = S_IFG;
          w_phase = 8'd0;
        end else begin
          w_txEn  = 1'b1;
          w_phase = r_phase + 8'd1;
          case (r_phase[1:0])
            2'd0:    w_txd = w_fcs[15:8];
            2'd1:    w_txd = w_fcs[23:16];
            default: w_txd = w_fcs[31:24];
          endcase
          // Count the frame as the final FCS byte is launched.
          if (r_phase[1:0] == 2'd2) w_frameCnt = r_frameCnt + 16'd1;
        end
      end
      S_ERR: begin
        w_phase = 8'd0;
        w_state = r_last ? S_IFG : S_DROP;
      end
      S_DROP: begin
        if (validIn && lastIn) begin
          w_state = S_IFG;
          w_phase = 8'd0;
        end
      end
      S_IFG: begin
        if (r_phase == IFG_LAST) begin
          // A waiting frame starts right as the gap ends, keeping back-to-back spacing exact.
          if (validIn) begin
            w_state = S_PRE;
            w_txd   = 8'h55;
            w_txEn  = 1'b1;
            w_phase = 8'd0;
            w_crc   = 32'hFFFFFFFF;
            w_bytes = 16'd0;
            w_last  = 1'b0;
          end else begin
            w_state = S_IDLE;
          end
        end else begin
          w_phase = r_phase + 8'd1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: a padding and a non-padding instance share one stimulus stream.
module tb_gmii_tx_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic        vin, lin;

  logic        a_ready, a_en, a_er, a_busy;
  logic [7:0]  a_txd;
  logic [15:0] a_frame;
  logic        b_ready, b_en, b_er, b_busy;
  logic [7:0]  b_txd;
  logic [15:0] b_frame;

  logic        sel;
  logic        m_ready, m_en, m_er;
  logic [7:0]  m_txd;

  always #4 clk = ~clk;

  gmii_tx_framer #(.IFG_CYCLES(12), .MIN_BYTES(60), .PAD_EN(1'b1)) u_dut (
    .txClk(clk), .rst(rst), .dataIn(din), .validIn(vin), .lastIn(lin),
    .readyOut(a_ready), .gmiiTxd(a_txd), .gmiiTxEn(a_en), .gmiiTxEr(a_er),
    .busyOut(a_busy), .frameCntOut(a_frame));

  gmii_tx_framer #(.IFG_CYCLES(12), .MIN_BYTES(60), .PAD_EN(1'b0)) u_np (
    .txClk(clk), .rst(rst), .dataIn(din), .validIn(vin), .lastIn(lin),
    .readyOut(b_ready), .gmiiTxd(b_txd), .gmiiTxEn(b_en), .gmiiTxEr(b_er),
    .busyOut(b_busy), .frameCntOut(b_frame));

  assign m_ready = sel ? b_ready : a_ready;
  assign m_en    = sel ? b_en    : a_en;
  assign m_er    = sel ? b_er    : a_er;
  assign m_txd   = sel ? b_txd   : a_txd;

  logic [7:0] fb [0:127];
  int         flen;
  logic [7:0] cap_q [$];
  logic [7:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;
  int en_cyc, er_cyc, first_en, rdy_after, acc_after_er, en_after_er;
  logic [7:0] er_txd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] fcs_model(input logic [7:0] m [$]);
    logic [31:0] c;
    logic        f;
    c = 32'hFFFFFFFF;
    foreach (m[i]) begin
      for (int b = 0; b < 8; b++) begin
        f = c[0] ^ m[i][b];
        c = c >> 1;
        if (f) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  task automatic build_exp(input bit pad);
    logic [7:0]  m [$];
    logic [31:0] f;
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < flen; i++) m.push_back(fb[i]);
    if (pad) while (m.size() < 60) m.push_back(8'h00);
    f = fcs_model(m);
    foreach (m[i]) exp_q.push_back(m[i]);
    exp_q.push_back(f[7:0]);
    exp_q.push_back(f[15:8]);
    exp_q.push_back(f[23:16]);
    exp_q.push_back(f[31:24]);
  endtask

  task automatic cmp_wire(input string tag, input int off);
    int mism;
    int n;
    mism = 0;
    n = cap_q.size();
    if (exp_q.size() - off < n) n = exp_q.size() - off;
    for (int i = 0; i < n; i++) if (cap_q[i] !== exp_q[i + off]) mism++;
    chk({tag, "_len"}, cap_q.size(), exp_q.size() - off);
    chk({tag, "_bytes_bad"}, mism, 0);
  endtask

  // Streams fb[0..flen-1], capturing the wire of the selected instance.
  task automatic drive_frame(input int gap_idx, input bit hold, input logic [7:0] hold_byte, input int rst_at);
    int idx;
    bit gap_done, er_seen, done;
    idx = 0; gap_done = 0; er_seen = 0; done = 0;
    cap_q.delete();
    en_cyc = 0; er_cyc = 0; first_en = -1; rdy_after = 0; acc_after_er = 0; en_after_er = 0;
    er_txd = 8'hFF;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      @(negedge clk);
      if (m_en) begin
        cap_q.push_back(m_txd);
        en_cyc++;
        if (first_en < 0) first_en = cyc;
        if (er_seen) en_after_er++;
      end
      if (m_er) begin er_cyc++; er_txd = m_txd; er_seen = 1; end
      if (rst_at > 0 && cap_q.size() == rst_at) begin
        rst = 1'b1; vin = 1'b0; lin = 1'b0; done = 1;
      end else if (idx == flen && !m_en) begin
        vin = hold; din = hold_byte; lin = 1'b0; done = 1;
      end else begin
        if (idx < flen && !(idx == gap_idx && !gap_done && m_ready)) begin
          vin = 1'b1; din = fb[idx]; lin = (idx == flen - 1);
        end else begin
          vin = 1'b0; lin = 1'b0;
          if (idx == gap_idx && m_ready) gap_done = 1;
        end
        if (idx == flen && m_ready) rdy_after++;
        if (vin && m_ready) begin
          idx++;
          if (er_seen) acc_after_er++;
        end
      end
    end
    chk("frame_complete", done, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (!a_busy && !b_busy) ok = 1;
    end
    chk("wait_idle", ok, 1);
  endtask

  initial begin
    int low;
    bit seen;
    rst = 1'b1; vin = 1'b0; lin = 1'b0; din = 8'h00; sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_txd", a_txd, 8'h00);
    chk("rst_txen", a_en, 1'b0);
    chk("rst_txer", a_er, 1'b0);
    chk("rst_ready", a_ready, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_frames", a_frame, 16'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: check string without padding.
    sel = 1'b1;
    flen = 9;
    for (int i = 0; i < 9; i++) fb[i] = 8'h31 + 8'(i);
    drive_frame(-1, 1'b0, 8'h00, 0);
    build_exp(1'b0);
    cmp_wire("t1_wire", 0);
    chk("t1_fcs_const", {cap_q[20], cap_q[19], cap_q[18], cap_q[17]}, 32'hCBF43926);
    chk("t1_txen_cycles", en_cyc, 21);
    chk("t1_first_latency", first_en, 1);
    chk("t1_frames", b_frame, 16'd1);
    wait_idle();

    // 2: short frame padded to 60 bytes.
    sel = 1'b0;
    flen = 14;
    for (int i = 0; i < 14; i++) fb[i] = 8'hA0 + 8'(i);
    drive_frame(-1, 1'b0, 8'h00, 0);
    build_exp(1'b1);
    cmp_wire("t2_wire", 0);
    chk("t2_ready_after_last", rdy_after, 0);
    chk("t2_frames", a_frame, 16'd2);
    wait_idle();

    // 3: back-to-back 64-byte frames.
    flen = 64;
    for (int i = 0; i < 64; i++) fb[i] = 8'(i * 3 + 1);
    drive_frame(-1, 1'b1, 8'h5A, 0);
    build_exp(1'b1);
    cmp_wire("t3_f1_wire", 0);
    low = 1; seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (a_en) seen = 1; else low++;
    end
    chk("t3_gap_seen", seen, 1);
    chk("t3_gap_cycles", low, 12);
    chk("t3_f2_first", a_txd, 8'h55);
    for (int i = 0; i < 64; i++) fb[i] = 8'(i) ^ 8'h5A;
    drive_frame(-1, 1'b0, 8'h00, 0);
    build_exp(1'b1);
    cmp_wire("t3_f2_wire", 1);
    chk("t3_frames", a_frame, 16'd4);
    wait_idle();

    // 4: underrun after byte index 20 of a 100-byte frame.
    flen = 100;
    for (int i = 0; i < 100; i++) fb[i] = 8'(i + 7);
    drive_frame(21, 1'b0, 8'h00, 0);
    chk("t4_er_cycles", er_cyc, 1);
    chk("t4_er_txd", er_txd, 8'h00);
    chk("t4_txen_after_err", en_after_er, 0);
    chk("t4_dropped", acc_after_er, 79);
    chk("t4_wire_len", cap_q.size(), 30);
    chk("t4_last_data", cap_q[28], 8'(20 + 7));
    chk("t4_frames", a_frame, 16'd4);
    low = 1; seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (!a_busy) seen = 1; else low++;
    end
    chk("t4_ifg_cycles", low, 12);

    // 5: reset during the second FCS byte, then a clean frame.
    flen = 64;
    for (int i = 0; i < 64; i++) fb[i] = 8'hFF - 8'(i);
    drive_frame(-1, 1'b0, 8'h00, 74);
    @(negedge clk);
    chk("t5_txen", a_en, 1'b0);
    chk("t5_txer", a_er, 1'b0);
    chk("t5_busy", a_busy, 1'b0);
    chk("t5_frames", a_frame, 16'd0);
    rst = 1'b0;
    @(negedge clk);
    drive_frame(-1, 1'b0, 8'h00, 0);
    build_exp(1'b1);
    cmp_wire("t5_wire", 0);
    chk("t5_frames_after", a_frame, 16'd1);
    wait_idle();

    // 6: frame counter wrap.
    @(negedge clk);
    force u_dut.r_frameCnt = 16'hFFFF;
    #1;
    release u_dut.r_frameCnt;
    @(negedge clk);
    chk("t6_preload", a_frame, 16'hFFFF);
    flen = 14;
    for (int i = 0; i < 14; i++) fb[i] = 8'h10 + 8'(i);
    drive_frame(-1, 1'b0, 8'h00, 0);
    chk("t6_wrap", a_frame, 16'h0000);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
